// File: rtl/alu_flag_stage.sv
// Flag stage after the add/sub datapath: derives Z/N/C/V, 1-cycle latency through a 2-entry skid FIFO.
// Backpressure: in_ready drops only when both entries are held; it never depends on out_ready combinationally.
module alu_flag_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_z,
    output logic             out_n,
    output logic             out_c,
    output logic             out_v,
    output logic             sticky_v,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] res_cnt
);

    logic [WIDTH-1:0] r_s [2];
    logic [1:0]       r_z;
    logic [1:0]       r_n;
    logic [1:0]       r_c;
    logic [1:0]       r_v;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_cnt;
    logic             r_live;
    logic             r_sticky;
    logic [CNT_W-1:0] r_res_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_rd;
    logic             w_z;
    logic             w_n;
    logic             w_c;
    logic             w_v;
    logic             w_b_eff;

    // Subtract feeds ~b to the adder, so overflow compares a against the effective b sign.
    assign w_b_eff = in_b_msb ^ in_sub;
    assign w_z     = (in_s == '0);
    assign w_n     = in_s[WIDTH-1];
    assign w_c     = in_cout ^ in_sub;
    assign w_v     = (in_a_msb == w_b_eff) && (in_s[WIDTH-1] != in_a_msb);

    assign in_ready  = r_live && (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // When empty, the head has already moved past the last popped entry; show that one instead.
    assign w_rd  = (r_cnt == 2'd0) ? ~r_head : r_head;
    assign out_s = r_s[w_rd];
    assign out_z = r_z[w_rd];
    assign out_n = r_n[w_rd];
    assign out_c = r_c[w_rd];
    assign out_v = r_v[w_rd];

    assign sticky_v = r_sticky;
    assign res_cnt  = r_res_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_s[i] <= '0;
            end
            r_z       <= '0;
            r_n       <= '0;
            r_c       <= '0;
            r_v       <= '0;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_cnt     <= 2'd0;
            r_live    <= 1'b0;
            r_sticky  <= 1'b0;
            r_res_cnt <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_s[r_tail] <= in_s;
                r_z[r_tail] <= w_z;
                r_n[r_tail] <= w_n;
                r_c[r_tail] <= w_c;
                r_v[r_tail] <= w_v;
                r_tail      <= ~r_tail;
            end
            if (w_pop) begin
                r_head    <= ~r_head;
                r_res_cnt <= r_res_cnt + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            // A V=1 pop in the same cycle as a clear keeps the sticky bit set.
            if (w_pop && out_v) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage: stimulus pushes expected entries, monitor pops on each delivered result.
module tb_alu_flag_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_s;
    logic       in_cout;
    logic       in_a_msb;
    logic       in_b_msb;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_s;
    logic       out_z;
    logic       out_n;
    logic       out_c;
    logic       out_v;
    logic       sticky_v;
    logic       clr_sticky;
    logic [15:0] res_cnt;

    typedef struct packed {
        logic [7:0] s;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_flag_stage #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_cout    (in_cout),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_z      (out_z),
        .out_n      (out_n),
        .out_c      (out_c),
        .out_v      (out_v),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky),
        .res_cnt    (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got s=0x%0h with no result pending", out_s);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({out_s, out_z, out_n, out_c, out_v} !== e) begin
                    n_err++;
                    $display("FAIL result: got s=%0h z%0b n%0b c%0b v%0b, expected s=%0h z%0b n%0b c%0b v%0b",
                             out_s, out_z, out_n, out_c, out_v, e.s, e.z, e.n, e.c, e.v);
                end
            end
        end
    end

    task automatic send(input logic [7:0] s, input logic co, input logic a, input logic b,
                        input logic sb, input exp_t e);
        in_s     = s;
        in_cout  = co;
        in_a_msb = a;
        in_b_msb = b;
        in_sub   = sb;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready stuck at %0b, expected 1", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) begin
            @(posedge clk);
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: {s, z, n, c, v}
    localparam exp_t E_ADD_OVF = {8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam exp_t E_SUB_EQ  = {8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam exp_t E_SUB_BOR = {8'hFE, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam exp_t E_SUB_OVF = {8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; in_s = '0; in_cout = 1'b0; in_a_msb = 1'b0;
        in_b_msb = 1'b0; in_sub = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_fields", {out_s, out_z, out_n, out_c, out_v}, 0);
        chk("rst_sticky", sticky_v, 0);
        chk("rst_res_cnt", res_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // Flag vectors, one at a time
        out_ready = 1'b1;
        send(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, E_ADD_OVF);
        drain();
        chk("sticky_after_v", sticky_v, 1);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("sticky_cleared", sticky_v, 0);
        send(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, E_SUB_EQ);
        send(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, E_SUB_BOR);
        send(8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, E_SUB_OVF);
        drain();
        chk("res_cnt_4", res_cnt, 4);

        // Backpressure: third result must wait, head stays on the first
        do_reset();
        out_ready = 1'b0;
        send(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, E_SUB_EQ);
        chk("rdy_after_1", in_ready, 1);
        send(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, E_SUB_BOR);
        chk("rdy_full", in_ready, 0);
        fork
            send(8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, E_SUB_OVF);
            begin
                repeat (3) @(negedge clk);
                chk("hold_rdy", in_ready, 0);
                chk("hold_head", {out_s, out_z, out_n, out_c, out_v}, E_SUB_EQ);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("res_cnt_3", res_cnt, 3);

        // Streaming: one result per cycle, never more than one buffered
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_cout = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0; in_sub = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_s = 8'(i * 9);
            e = {in_s, (in_s == 8'h00), 1'b0, 1'b0, 1'b0};
            @(negedge clk);
            chk("stream_rdy", in_ready, 1);
            if (i > 0) chk("stream_vld", out_valid, 1);
            if (in_ready === 1'b1) q.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("res_cnt_13", res_cnt, 13);

        // Clear and V=1 pop in the same cycle: set wins
        out_ready = 1'b0;
        send(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, E_ADD_OVF);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        chk("sticky_clr_idle", sticky_v, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("sticky_set_wins", sticky_v, 1);

        // Reset with two entries buffered, with out_ready high in the reset cycle
        out_ready = 1'b0;
        send(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, E_SUB_BOR);
        send(8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, E_SUB_OVF);
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_res_cnt", res_cnt, 0);
        chk("midrst_sticky", sticky_v, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("midrst_in_ready_back", in_ready, 1);

        // Counter wrap after 0xFFFF pops
        in_valid = 1'b1;
        in_s = 8'h01; in_cout = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0; in_sub = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) q.push_back({8'h01, 1'b0, 1'b0, 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("res_cnt_ffff", res_cnt, 32'h0000FFFF);
        send(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, E_SUB_EQ);
        drain();
        chk("res_cnt_wrap", res_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
